// File: rtl/cmp8_share_arb.sv
// rtl/cmp8_share_arb.sv - round-robin arbiter sharing one cmp8 comparator among N requesters
//
// Purpose: grants one of N requesters at a time, registers its operand pair into a
// single shared unsigned 8-bit comparator, captures the lt/eq/gt flags and returns
// them tagged with the requester index over a valid/ready response channel.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   req_valid  [N]    per-requester operand pair present
//   req_a      [8*N]  operand A of requester r at [8r+7:8r]
//   req_b      [8*N]  operand B of requester r at [8r+7:8r]
//   req_ready  [N]    one-hot grant, only ever high in IDLE
//   rsp_valid         response held on rsp_*
//   rsp_ready         consumer takes the response
//   rsp_id     [IW]   owner of the response
//   rsp_lt/eq/gt      comparison result flags, exactly one set while rsp_valid
//   busy              state is not IDLE

module cmp8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       lt,
   output logic       eq,
   output logic       gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

module cmp8_share_arb #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req_valid,
   input  logic [8*N-1:0] req_a,
   input  logic [8*N-1:0] req_b,
   output logic [N-1:0]   req_ready,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IW-1:0]  rsp_id,
   output logic           rsp_lt,
   output logic           rsp_eq,
   output logic           rsp_gt,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] ptr;
   logic [IW-1:0] id_q;
   logic [7:0]    op_a;
   logic [7:0]    op_b;
   logic [IW-1:0] win_id;
   logic          win_found;
   logic [N-1:0]  grant;
   logic          accept;
   logic          c_lt;
   logic          c_eq;
   logic          c_gt;

   // (base + off) mod N for off in 0..N-1; works for non-power-of-two N
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return s[IW-1:0];
   endfunction

   // First valid requester starting at ptr; ptr itself has top priority
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < N; i++) begin
         if (!win_found && req_valid[wrap_add(ptr, i)]) begin
            win_found = 1'b1;
            win_id    = wrap_add(ptr, i);
         end
      end
   end

   // Grant is gated by reset so req_ready reads zero for the whole reset pulse
   always_comb begin
      grant = '0;
      if (state == IDLE && !reset && win_found)
         grant[win_id] = 1'b1;
   end

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);
   assign busy      = (state != IDLE);

   // Comparator only ever sees registered operands
   cmp8 u_cmp8 (
      .a  (op_a),
      .b  (op_b),
      .lt (c_lt),
      .eq (c_eq),
      .gt (c_gt)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = CMP;
         CMP:     state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         id_q      <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_lt    <= 1'b0;
         rsp_eq    <= 1'b0;
         rsp_gt    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a <= req_a[int'(win_id)*8 +: 8];
                  op_b <= req_b[int'(win_id)*8 +: 8];
                  id_q <= win_id;
               end
            end
            CMP: begin
               rsp_lt    <= c_lt;
               rsp_eq    <= c_eq;
               rsp_gt    <= c_gt;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               // Served requester drops to lowest priority
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= wrap_add(rsp_id, 1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp8_share_arb.sv
// tb/tb_cmp8_share_arb.sv - self-checking bench for cmp8_share_arb

module tb_cmp8_share_arb;

   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_a;
   logic [8*N-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IW-1:0]  rsp_id;
   logic           rsp_lt;
   logic           rsp_eq;
   logic           rsp_gt;
   logic           busy;

   int n_pass;
   int n_total;

   cmp8_share_arb #(.N(N), .IW(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_lt    (rsp_lt),
      .rsp_eq    (rsp_eq),
      .rsp_gt    (rsp_gt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      logic       lt;
      logic       eq;
      logic       gt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Single isolated transaction, rsp_ready high; starts and ends just after a rising edge
   task automatic run_txn(input int r, input logic [7:0] a, input logic [7:0] b,
                          input logic elt, input logic eeq, input logic egt);
      logic [N-1:0] onehot;
      onehot = '0;
      onehot[r] = 1'b1;
      req_a[r*8 +: 8] = a;
      req_b[r*8 +: 8] = b;
      req_valid = onehot;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("txn_grant", 32'(req_ready), 32'(onehot));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("txn_cmp_novalid", 32'(rsp_valid), 32'd0);
      check("txn_cmp_busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("txn_rsp_valid", 32'(rsp_valid), 32'd1);
      check("txn_rsp_id", 32'(rsp_id), 32'(r));
      check("txn_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'({elt, eeq, egt}));
      @(posedge clk);
      @(negedge clk);
      check("txn_done_valid", 32'(rsp_valid), 32'd0);
      check("txn_done_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int         acc_cyc[$];
      int         nrsp;
      int         bad;
      logic [7:0] ra;

      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{2, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{0, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{3, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{2, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{3, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0};

      // Reset with all requesters valid: nothing granted, outputs zero
      reset     = 1'b1;
      req_valid = 4'b1111;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_fields", 32'({rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'd0);
      @(posedge clk); #1;
      req_valid = '0;
      reset     = 1'b0;

      // Table of single transactions, including flag coverage
      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].lt, vecs[i].eq, vecs[i].gt);

      // Round robin: all valid continuously, rsp_ready high
      do_reset();
      for (int r = 0; r < N; r++) begin
         req_a[r*8 +: 8] = 8'(r * 8'h40);
         req_b[r*8 +: 8] = 8'h40;
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != '0) acc_cyc.push_back(c);
         if (rsp_valid && nrsp < 6) begin
            ra = 8'((nrsp % N) * 8'h40);
            check("rr_id", 32'(rsp_id), 32'(nrsp % N));
            check("rr_flags", 32'({rsp_lt, rsp_eq, rsp_gt}),
                  32'({ra < 8'h40, ra == 8'h40, ra > 8'h40}));
            nrsp++;
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      check("rr_rsp_count", 32'(nrsp), 32'd6);
      check("rr_acc_count_min", 32'(acc_cyc.size() >= 6), 32'd1);
      for (int k = 1; k < 6 && k < acc_cyc.size(); k++)
         check("rr_acc_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);

      // Backpressure in RESP, then ptr wrap 3 -> 0
      do_reset();
      req_a[31:24] = 8'h10;
      req_b[31:24] = 8'h20;
      req_valid = 4'b1000;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_grant", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}),
               32'({1'b1, 2'd3, 1'b1, 1'b0, 1'b0}));
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_last_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_idle", 32'({busy, rsp_valid}), 32'd0);
      check("bp_wrap_grant", 32'(req_ready), 32'b0001);
      req_valid = '0;
      @(posedge clk); #1;

      // Asynchronous reset mid-cycle while holding a response
      do_reset();
      req_a[23:16] = 8'hFF;
      req_b[23:16] = 8'h00;
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(posedge clk);
      @(negedge clk);
      check("ar_pre_rsp", 32'({rsp_valid, rsp_id, rsp_gt}), 32'({1'b1, 2'd2, 1'b1}));
      #2;
      reset = 1'b1;
      #1;
      check("ar_rsp_cleared", 32'({rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt}), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset in CMP discards the transaction; arbitration restarts at 0
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rc_grant", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = '0;
      check("rc_in_cmp", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rc_busy_cleared", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      check("rc_no_response", 32'(bad), 32'd0);
      req_valid = 4'b1001;
      @(negedge clk);
      check("rc_restart_grant", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cmp8_share_arb.md
# cmp8_share_arb

Round-robin arbiter and sequencer sharing one `cmp8` unsigned 8-bit magnitude comparator among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, registers its operands into the comparator, captures the three result flags, and returns them with the requester's index over a valid/ready response channel. It sits between the ALU's compare clients and the single comparator instance, which it instantiates internally.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `IW`, default 2: width of the requester index, equal to clog2(N).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N  bit r: requester r presents an operand pair.
- `req_a`  in  8*N  operand A of requester r at bits [8r+7:8r].
- `req_b`  in  8*N  operand B of requester r at bits [8r+7:8r].
- `req_ready`  out  N  one-hot grant; requester r's pair is accepted when `req_valid[r] & req_ready[r]`.
- `rsp_valid`  out  1  a response is held on the `rsp_*` outputs.
- `rsp_ready`  in  1  the consumer takes the response.
- `rsp_id`  out  IW  index of the requester that owns the response.
- `rsp_lt`  out  1  A < B, unsigned.
- `rsp_eq`  out  1  A == B.
- `rsp_gt`  out  1  A > B, unsigned.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester searching `ptr`, `ptr+1`, … mod N.
  - `req_ready` is combinational: one-hot on the granted requester, zero when no `req_valid` is high.
  - On acceptance, latch `req_a`/`req_b` of the winner into `op_a`/`op_b` and its index into `id_q`, then go to CMP.
- CMP:
  - `cmp8` inputs are `op_a`/`op_b`, which are registered, so there is no combinational path from the request ports to the comparator.
  - Register the comparator outputs: eq → `rsp_eq`, gt → `rsp_gt`, lt → `rsp_lt`. Set `rsp_id <= id_q` and `rsp_valid <= 1`, then go to RESP.
- RESP:
  - Hold all `rsp_*` outputs stable while `rsp_ready` is low.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid`, set `ptr <= (rsp_id + 1) mod N`, go to IDLE.
- `req_ready` is all zeros in CMP and RESP. There is no acceptance during RESP, even in the cycle where `rsp_ready` is high.
- Result invariant: exactly one of `rsp_lt`/`rsp_eq`/`rsp_gt` is high whenever `rsp_valid` is high.
- Requester rules:
  - A requester must hold `req_valid` and its operands until accepted.
  - Deasserting `req_valid` before acceptance simply removes it from arbitration. This is not an error.
- Fairness: after requester r is served, it has lowest priority. With all N requesting continuously, service order is a strict rotation and no requester waits more than N-1 transactions.
- `ptr` wraps from N-1 to 0.

## Timing
- Reset values, applied asynchronously while `reset` is high:
  - state IDLE, `ptr` 0, `rsp_valid` 0.
  - `rsp_id`, `rsp_lt`, `rsp_eq`, `rsp_gt` all 0.
  - `op_a`, `op_b`, `id_q` all 0.
  - `req_ready` forced all zeros; `busy` 0.
- Latency: acceptance edge at cycle T, `rsp_valid` high from cycle T+2.
- Minimum transaction period is 3 cycles (IDLE, CMP, RESP) with `rsp_ready` tied high.
- Reset mid-transaction, in CMP or RESP: the transaction is discarded and no response is produced. After release, arbitration restarts at `ptr` = 0.
- New `req_valid` arrivals during CMP/RESP are only evaluated on return to IDLE.
- Release of `reset` is synchronous to `clk` by convention. The first grant is possible in the first cycle after release.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 immediately; hold `req_valid`=4'b1111 during reset → `req_ready` stays 4'b0000.
- Single request:
  - Requester 2 with A=0x80, B=0x7F, accepted at T → at T+2 `rsp_valid`=1, `rsp_id`=2, gt=1, lt=0, eq=0.
  - Consume with `rsp_ready`=1 → `rsp_valid`=0 at T+3.
- Flag coverage:
  - A=B=0xA5 → eq=1.
  - A=0x00, B=0xFF → lt=1.
  - A=0xFF, B=0x00 → gt=1.
  - A=0x01, B=0x80 → lt=1 (unsigned).
- Round-robin: all four requesters valid continuously with `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1; acceptances exactly 3 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, `req_ready`=0, `busy`=1; raise `rsp_ready` → IDLE next cycle.
- Reset in CMP: requester 1 accepted, assert `reset` the next cycle → no `rsp_valid`. After release, requesters 0 and 3 both valid → requester 0 granted first.
